// File: rtl/riscv_data_mem.sv
// Data memory responder for the multi-cycle core: accepts one load/store request,
// waits a fixed latency, then commits and pulses ready (with err on a rejected request).
module riscv_data_mem #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_RE,
    input  logic        mem_WE,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic        lat_re;
    logic        lat_we;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_funct3;
    logic          cur_re;
    logic          cur_we;
    logic [IW-1:0] word_idx;
    logic          commit;
    logic          req_err;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   load_val;
    logic          unused_addr_bits;

    // With LATENCY==1 the commit happens on the accept edge, so the live inputs are used.
    always_comb begin
        cur_addr   = lat_addr;
        cur_wdata  = lat_wdata;
        cur_funct3 = lat_funct3;
        cur_re     = lat_re;
        cur_we     = lat_we;
        if (state == IDLE) begin
            cur_addr   = addr;
            cur_wdata  = wdata;
            cur_funct3 = funct3;
            cur_re     = mem_RE;
            cur_we     = mem_WE;
        end
    end

    assign word_idx         = cur_addr[IW+1:2];
    assign unused_addr_bits = ^cur_addr[31:IW+2];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mem_RE || mem_WE) begin
                    cnt_next   = CNT_INIT;
                    state_next = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state != DONE) && (state_next == DONE);

    always_comb begin
        req_err = 1'b0;
        if (cur_re && cur_we) begin
            req_err = 1'b1;
        end
        if ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) begin
            req_err = 1'b1;
        end
        if ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
        if (cur_re && ((cur_funct3[1:0] == 2'b11) || (cur_funct3 == 3'b110))) begin
            req_err = 1'b1;
        end
        if (cur_we && (cur_funct3[2] || (cur_funct3[1:0] == 2'b11))) begin
            req_err = 1'b1;
        end
    end

    // Store data is replicated across lanes; byte_en picks which lanes actually change.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = cur_wdata;
        case (cur_funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << cur_addr[1:0];
                store_word = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
                store_word = {2{cur_wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
        case (cur_funct3)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'h0, rd_shift[7:0]};
            3'b101:  load_val = {16'h0, rd_shift[15:0]};
            default: load_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata      <= 32'h0;
            ready      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_funct3 <= 3'b000;
            lat_re     <= 1'b0;
            lat_we     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= commit;
            err   <= commit && req_err;
            busy  <= (state_next != IDLE);
            if ((state == IDLE) && (mem_RE || mem_WE)) begin
                lat_addr   <= addr;
                lat_wdata  <= wdata;
                lat_funct3 <= funct3;
                lat_re     <= mem_RE;
                lat_we     <= mem_WE;
            end
            if (commit && cur_re) begin
                rdata <= req_err ? 32'h0 : load_val;
            end
        end
    end

    // The array has no reset; only a committed, error-free store touches it.
    always_ff @(posedge clk) begin
        if (rst_n && commit && cur_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

endmodule
